// File: rtl/io_pkg.sv
`timescale 1ns/1ps
// io_pkg: shared definitions for the memory-mapped board I/O controller.
//
// Holds the register word offsets inside the 8-word I/O window, the default
// window base address, and the decode helpers the top level uses to choose
// between RAM and I/O read data.
//
// Optional feature macro: IO_IRQ_EN. It enables the MASK register and the
// irq output in mmio_io_ctrl. IO_OFF_MASK is always defined here.
package io_pkg;

    localparam logic [2:0]  IO_OFF_SW    = 3'd0;
    localparam logic [2:0]  IO_OFF_BTN   = 3'd1;
    localparam logic [2:0]  IO_OFF_PRESS = 3'd2;
    localparam logic [2:0]  IO_OFF_LED   = 3'd3;
    localparam logic [2:0]  IO_OFF_MASK  = 3'd4;

    localparam logic [11:0] IO_BASE_ADDR_DEFAULT = 12'hF00;

    // The window is 8 words, so only address bits [11:3] take part in the hit.
    function automatic logic io_addr_hit(input logic [11:0] addr,
                                         input logic [11:0] base);
        return addr[11:3] == base[11:3];
    endfunction

    // Top-level read mux: I/O data when the window was hit, RAM data otherwise.
    function automatic logic [31:0] io_read_mux(input logic        io_sel,
                                                input logic [31:0] io_data,
                                                input logic [31:0] ram_data);
        return io_sel ? io_data : ram_data;
    endfunction

endpackage

// File: rtl/io_debounce.sv
`timescale 1ns/1ps
// io_debounce: synchronise and debounce one raw asynchronous input.
//
// Ports:
//   clock  - sole clock, rising edge
//   reset  - asynchronous, active-low
//   in     - raw asynchronous input
//   stable - debounced level, changes only after the synchronised input has
//            differed from it for DEBOUNCE_CYCLES consecutive cycles
//
// Parameter DEBOUNCE_CYCLES (>= 1) sets the required stable run length.
module io_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000
) (
    input  logic clock,
    input  logic reset,
    input  logic in,
    output logic stable
);

    localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             sync1_q, sync1_d;
    logic             sync2_q, sync2_d;
    logic             stable_q, stable_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        sync1_d  = in;
        sync2_d  = sync1_q;
        stable_d = stable_q;
        cnt_d    = '0;
        // Any cycle where the synchronised value agrees with stable restarts
        // the run. The cycle that would bring the count to DEBOUNCE_CYCLES
        // flips stable instead, so the counter never wraps.
        if (sync2_q != stable_q) begin
            if (cnt_q == CNT_LAST) begin
                stable_d = ~stable_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_q  <= 1'b0;
            sync2_q  <= 1'b0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            sync1_q  <= sync1_d;
            sync2_q  <= sync2_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
        end
    end

    assign stable = stable_q;

endmodule

// File: rtl/mmio_io_ctrl.sv
`timescale 1ns/1ps
// mmio_io_ctrl: memory-mapped switch / button / LED controller on the dmem bus.
//
// Ports:
//   clock, reset     - rising-edge clock, asynchronous active-low reset
//   addr, wEn, dataIn- dmem bus word address, write enable, write data
//   dataOut          - registered read data (1-cycle latency, like RAM)
//   sel              - combinational window hit, for the top-level read mux
//   SW, BTN          - raw asynchronous switch / button inputs
//   LED              - registered LED drive
//   irq              - registered interrupt, only when IO_IRQ_EN is defined
//
// Register map (word offset addr[2:0]):
//   0 SW (ro), 1 BTN (ro), 2 PRESS (sticky, W1C), 3 LED (rw),
//   4 MASK (rw, IO_IRQ_EN only, otherwise reads 0), 5-7 reserved (read 0).
//
// Optional feature macro: IO_IRQ_EN.
module mmio_io_ctrl
    import io_pkg::*;
#(
    parameter int          N_SW            = 16,
    parameter int          N_BTN           = 5,
    parameter int          N_LED           = 16,
    parameter int          DEBOUNCE_CYCLES = 1000000,
    parameter logic [11:0] BASE_ADDR       = IO_BASE_ADDR_DEFAULT
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [11:0]      addr,
    input  logic             wEn,
    input  logic [31:0]      dataIn,
    output logic [31:0]      dataOut,
    output logic             sel,
    input  logic [N_SW-1:0]  SW,
    input  logic [N_BTN-1:0] BTN,
    output logic [N_LED-1:0] LED
`ifdef IO_IRQ_EN
    ,
    output logic             irq
`endif
);

    localparam int N_IN = N_SW + N_BTN;

    logic [N_IN-1:0]  raw_in;
    logic [N_IN-1:0]  db_in;
    logic [N_SW-1:0]  sw_db;
    logic [N_BTN-1:0] btn_db;

    assign raw_in = {BTN, SW};

    for (genvar i = 0; i < N_IN; i++) begin : g_db
        io_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_db (
            .clock  (clock),
            .reset  (reset),
            .in     (raw_in[i]),
            .stable (db_in[i])
        );
    end

    assign sw_db  = db_in[N_SW-1:0];
    assign btn_db = db_in[N_IN-1:N_SW];

    logic [2:0] off;
    logic       wr;

    assign sel = io_addr_hit(addr, BASE_ADDR);
    assign off = addr[2:0];
    assign wr  = sel & wEn;

    // Upper write-data bits beyond the register widths are ignored.
    logic unused_din;
    assign unused_din = ^dataIn;

    logic [N_BTN-1:0] btn_prev_q, btn_prev_d;
    logic [N_BTN-1:0] press_q, press_d;
    logic [N_BTN-1:0] press_clr;
    logic [N_LED-1:0] led_q, led_d;
    logic [31:0]      dout_q, dout_d;

`ifdef IO_IRQ_EN
    logic [N_BTN-1:0] mask_q, mask_d;
    logic             irq_q, irq_d;

    always_comb begin
        mask_d = mask_q;
        if (wr && off == IO_OFF_MASK) begin
            mask_d = dataIn[N_BTN-1:0];
        end
        // Built from the registered flags, so irq lags a PRESS set, MASK write
        // or W1C clear by exactly one cycle.
        irq_d = |(press_q & mask_q);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            mask_q <= '0;
            irq_q  <= 1'b0;
        end else begin
            mask_q <= mask_d;
            irq_q  <= irq_d;
        end
    end

    assign irq = irq_q;
`endif

    always_comb begin
        btn_prev_d = btn_db;
        press_clr  = (wr && off == IO_OFF_PRESS) ? dataIn[N_BTN-1:0] : '0;
        // Set is OR-ed in after the clear, so a rising edge in the same cycle
        // as a W1C of that bit leaves the flag set. Falling edges are ignored.
        press_d    = (press_q & ~press_clr) | (btn_db & ~btn_prev_q);

        led_d = led_q;
        if (wr && off == IO_OFF_LED) begin
            led_d = dataIn[N_LED-1:0];
        end

        // Read mux uses current register state, so a read colliding with a
        // write to the same register returns the pre-write value.
        dout_d = '0;
        if (sel) begin
            case (off)
                IO_OFF_SW:    dout_d = 32'(sw_db);
                IO_OFF_BTN:   dout_d = 32'(btn_db);
                IO_OFF_PRESS: dout_d = 32'(press_q);
                IO_OFF_LED:   dout_d = 32'(led_q);
`ifdef IO_IRQ_EN
                IO_OFF_MASK:  dout_d = 32'(mask_q);
`endif
                default:      dout_d = '0;
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            btn_prev_q <= '0;
            press_q    <= '0;
            led_q      <= '0;
            dout_q     <= '0;
        end else begin
            btn_prev_q <= btn_prev_d;
            press_q    <= press_d;
            led_q      <= led_d;
            dout_q     <= dout_d;
        end
    end

    assign dataOut = dout_q;
    assign LED     = led_q;

endmodule

// File: tb/tb_mmio_io_ctrl.sv
`timescale 1ns/1ps
// tb_mmio_io_ctrl: directed testbench for mmio_io_ctrl with DEBOUNCE_CYCLES=4,
// 16 switches, 5 buttons, 16 LEDs, window at 12'hF00.
// Optional feature macro: IO_IRQ_EN (adds MASK/irq scenarios).
module tb_mmio_io_ctrl;

  localparam int          N_SW  = 16;
  localparam int          N_BTN = 5;
  localparam int          N_LED = 16;
  localparam int          DEB   = 4;
  localparam logic [11:0] BASE  = 12'hF00;
  localparam int          N_IN  = N_SW + N_BTN;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic [11:0]      addr   = '0;
  logic             wEn    = 1'b0;
  logic [31:0]      dataIn = '0;
  logic [31:0]      dataOut;
  logic             sel;
  logic [N_SW-1:0]  SW     = '0;
  logic [N_BTN-1:0] BTN    = '0;
  logic [N_LED-1:0] LED;
`ifdef IO_IRQ_EN
  logic             irq;
`endif

  mmio_io_ctrl #(
    .N_SW(N_SW), .N_BTN(N_BTN), .N_LED(N_LED),
    .DEBOUNCE_CYCLES(DEB), .BASE_ADDR(BASE)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .addr    (addr),
    .wEn     (wEn),
    .dataIn  (dataIn),
    .dataOut (dataOut),
    .sel     (sel),
    .SW      (SW),
    .BTN     (BTN),
    .LED     (LED)
`ifdef IO_IRQ_EN
    ,
    .irq     (irq)
`endif
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Debounce: a bit's level is accepted once the input, seen two edges late,
  // has disagreed with the current level on DEB consecutive edges.
  logic [N_IN-1:0]  hist[$];
  logic [N_IN-1:0]  win[$];
  logic [N_IN-1:0]  m_stable;
  logic [N_BTN-1:0] m_btn_prev, m_press, m_mask;
  logic [N_LED-1:0] m_led;
  logic             m_irq;
  logic [31:0]      m_dout;

  function automatic logic [31:0] model_read(input logic [11:0] a);
    if (a[11:3] != BASE[11:3]) return 32'h0;
    case (a[2:0])
      3'd0: return 32'(m_stable[N_SW-1:0]);
      3'd1: return 32'(m_stable[N_IN-1:N_SW]);
      3'd2: return 32'(m_press);
      3'd3: return 32'(m_led);
`ifdef IO_IRQ_EN
      3'd4: return 32'(m_mask);
`endif
      default: return 32'h0;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin : model_step
    logic             wr;
    logic [N_BTN-1:0] btn_now, rise, clr;
    logic [N_IN-1:0]  s, diff;
    logic             irq_next;
    if (!reset) begin
      hist.delete();
      hist.push_back('0);
      hist.push_back('0);
      win.delete();
      m_stable   = '0;
      m_btn_prev = '0;
      m_press    = '0;
      m_mask     = '0;
      m_led      = '0;
      m_irq      = 1'b0;
      m_dout     = '0;
    end else begin
      wr       = wEn && (addr[11:3] == BASE[11:3]);
      m_dout   = model_read(addr);
      btn_now  = m_stable[N_IN-1:N_SW];
      rise     = btn_now & ~m_btn_prev;
      clr      = (wr && addr[2:0] == 3'd2) ? dataIn[N_BTN-1:0] : '0;
      irq_next = |(m_press & m_mask);
      m_press  = (m_press & ~clr) | rise;
      m_btn_prev = btn_now;
      if (wr && addr[2:0] == 3'd3) m_led = dataIn[N_LED-1:0];
`ifdef IO_IRQ_EN
      if (wr && addr[2:0] == 3'd4) m_mask = dataIn[N_BTN-1:0];
      m_irq = irq_next;
`endif
      s = hist.pop_front();
      hist.push_back({BTN, SW});
      win.push_back(s);
      if (win.size() > DEB) void'(win.pop_front());
      diff = '1;
      if (win.size() < DEB) diff = '0;
      else foreach (win[i]) diff &= (win[i] ^ m_stable);
      m_stable = m_stable ^ diff;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clock) begin
    if (reset) begin
      chk("cyc_dout", dataOut, m_dout);
      chk("cyc_led", 32'(LED), 32'(m_led));
      chk("cyc_sel", 32'(sel), 32'(addr[11:3] == BASE[11:3]));
`ifdef IO_IRQ_EN
      chk("cyc_irq", 32'(irq), 32'(m_irq));
`endif
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic bus_write(input logic [11:0] a, input logic [31:0] d);
    addr = a; dataIn = d; wEn = 1'b1;
    cyc(1);
    wEn = 1'b0;
  endtask

  task automatic bus_read(input logic [11:0] a, input logic [31:0] exp, input string name);
    addr = a; wEn = 1'b0;
    cyc(1);
    chk(name, dataOut, exp);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    SW = 16'hFFFF;
    cyc(3);
    chk("rst_dout", dataOut, 32'h0);
    chk("rst_led", 32'(LED), 32'h0);
    reset = 1'b1;
    addr  = 12'hF00;
    cyc(1);
    chk("sw_early", dataOut, 32'h0);
    cyc(6);
    chk("sw_settled", dataOut, 32'h0000FFFF);

    // glitch rejection, then a real press
    BTN = 5'b00001; cyc(3); BTN = 5'b00000; cyc(8);
    bus_read(12'hF01, 32'h0, "glitch_btn");
    bus_read(12'hF02, 32'h0, "glitch_press");
    BTN = 5'b00001; cyc(6);
    bus_read(12'hF01, 32'h1, "held_btn");
    bus_read(12'hF02, 32'h1, "held_press");

    // W1C and release
    bus_write(12'hF02, 32'h1);
    bus_read(12'hF02, 32'h0, "w1c_clear");
    BTN = 5'b00000; cyc(10);
    bus_read(12'hF02, 32'h0, "release_no_set");
    BTN = 5'b01000; cyc(8);
    bus_read(12'hF02, 32'h8, "press_btn3");
    bus_write(12'hF02, 32'hFFFF_FFFF);
    BTN = 5'b00000; cyc(8);
    bus_read(12'hF02, 32'h0, "clear_all");

    // set and W1C on the same edge: set wins
    BTN = 5'b00100; cyc(6);
    bus_write(12'hF02, 32'h4);
    bus_read(12'hF02, 32'h4, "conflict_set_wins");
    bus_write(12'hF02, 32'h4);
    BTN = 5'b00000; cyc(8);

    // LED and window
    bus_write(12'hF03, 32'hDEADBEEF);
    chk("led_write", 32'(LED), 32'h0000BEEF);
    bus_read(12'hF03, 32'h0000BEEF, "led_read");
    addr = 12'hEFF; #1;
    chk("sel_outside", 32'(sel), 32'h0);
    bus_write(12'hEFF, 32'h12345678);
    chk("led_outside", 32'(LED), 32'h0000BEEF);
    bus_read(12'hEFF, 32'h0, "rd_outside");
    addr = 12'hF03; dataIn = 32'h0000_1234; wEn = 1'b1;
    cyc(1);
    wEn = 1'b0;
    chk("rdw_old", dataOut, 32'h0000BEEF);
    chk("rdw_led", 32'(LED), 32'h00001234);

    // reserved offsets and MASK slot
    bus_write(12'hF06, 32'hFFFF_FFFF);
    bus_read(12'hF06, 32'h0, "rsvd6");
    bus_read(12'hF05, 32'h0, "rsvd5");
    bus_write(12'hF04, 32'h1F);
`ifdef IO_IRQ_EN
    bus_read(12'hF04, 32'h1F, "mask_rw");
    bus_write(12'hF04, 32'h0);
`else
    bus_read(12'hF04, 32'h0, "off4_zero");
`endif

    // switch change
    SW = 16'h0F0F; cyc(6);
    bus_read(12'hF00, 32'h00000F0F, "sw_change");

    // reset in the middle of a debounce run
    BTN = 5'b10000; cyc(3);
    reset = 1'b0; cyc(1);
    chk("rst_mid_led", 32'(LED), 32'h0);
    reset = 1'b1; addr = 12'hF01;
    cyc(6);
    chk("rst_mid_partial", dataOut, 32'h0);
    cyc(1);
    chk("rst_mid_done", dataOut, 32'h10);
    BTN = 5'b00000; cyc(8);
    bus_write(12'hF02, 32'h1F);

`ifdef IO_IRQ_EN
    bus_write(12'hF04, 32'h2);
    BTN = 5'b00001; cyc(8);
    chk("irq_masked", 32'(irq), 32'h0);
    BTN = 5'b00011; cyc(7);
    chk("irq_pre", 32'(irq), 32'h0);
    cyc(1);
    chk("irq_rise", 32'(irq), 32'h1);
    bus_write(12'hF02, 32'h2);
    chk("irq_hold", 32'(irq), 32'h1);
    cyc(1);
    chk("irq_fall", 32'(irq), 32'h0);
`endif

    cyc(2);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation did not complete within 50000 ns");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/mmio_io_ctrl.md
# mmio_io_ctrl

Memory-mapped board I/O controller that replaces ad-hoc wiring of switches, buttons and LEDs into the register file. It sits on the processor's data-memory bus beside RAM and claims a small address window. Inside that window it exposes debounced switch and button state, sticky button-press flags and a writable LED register. Channel counts, debounce interval and base address are all parametrised.

## Interface
- `N_SW`, 16: number of switch inputs (1–32).
- `N_BTN`, 5: number of button inputs (1–32).
- `N_LED`, 16: number of LED outputs (1–32).
- `DEBOUNCE_CYCLES`, 1000000: consecutive stable cycles required before an input change is accepted (10 ms at 100 MHz); must be ≥ 1.
- `BASE_ADDR`, 12'hF00: window base; bits [2:0] must be 0.
- `clock`  in  1  sole clock; all logic on the rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `addr`  in  12  word address from the dmem bus.
- `wEn`  in  1  write enable.
- `dataIn`  in  32  write data.
- `dataOut`  out  32  registered read data.
- `sel`  out  1  combinational window hit (`addr[11:3] == BASE_ADDR[11:3]`), used by the top-level read mux.
- `SW`  in  `N_SW`  raw asynchronous switch inputs.
- `BTN`  in  `N_BTN`  raw asynchronous button inputs.
- `LED`  out  `N_LED`  LED drive, registered.
- `irq`  out  1  present only when `IO_IRQ_EN` is defined.

## Operation
- Every SW and BTN bit passes through an `io_debounce` instance, producing a debounced `stable` bit.
- Register map, by word offset `addr[2:0]`:
  - 0 SW: read-only; debounced switches, zero-extended.
  - 1 BTN: read-only; debounced button levels.
  - 2 PRESS: sticky flag per button. A bit is set on a 0→1 transition of its debounced level. Writing 1 to a bit clears it (W1C); writing 0 has no effect.
  - 3 LED: read/write; `dataIn[N_LED-1:0]` is stored, upper bits are ignored, and reads return the stored value zero-extended.
  - 4 MASK: exists only with `IO_IRQ_EN`.
  - 5–7: reserved; read 0, writes ignored.
- Writes with `sel` = 0 are ignored. A read with `sel` = 0 returns 0 on the next cycle.
- Debounce behaviour:
  - A 2-flop synchroniser feeds a counter of width `$clog2(DEBOUNCE_CYCLES+1)`.
  - The counter clears whenever the synchronised value equals `stable`, and increments otherwise.
  - When the count reaches `DEBOUNCE_CYCLES`, `stable` toggles and the counter clears.
  - A glitch shorter than `DEBOUNCE_CYCLES` cycles restarts the count, so it is never accepted. The counter never wraps.
- Simultaneous events:
  - If a PRESS set and a W1C clear of the same bit occur in the same cycle, the set wins and the bit reads 1.
  - A debounced release (1→0) does not affect PRESS.
- Reset values: `dataOut` 0, `LED` 0, `irq` 0, all `stable` 0, all counters 0, all synchroniser flops 0, PRESS 0, MASK 0.
  - Asserting `reset` mid-debounce discards the partial count.

## Timing
- Raw input to `stable` change: 2 synchroniser cycles, then `DEBOUNCE_CYCLES` cycles.
- `stable` to PRESS set: 1 cycle.
- Read latency: 1 cycle, matching RAM. `dataOut` at edge N+1 reflects register state sampled at edge N.
  - A read issued in the same cycle as a write to the same register returns the pre-write value.
- LED write: `LED` updates at the write edge.
- `sel` is combinational from `addr`. No other combinational input-to-output path exists.

## Configuration
- `IO_IRQ_EN`, when defined, adds:
  - Register 4 MASK, read/write, `N_BTN` bits.
  - Port `irq`, registered: `irq` = |(PRESS & MASK), updated each cycle, so it asserts 1 cycle after a PRESS set or MASK write.
  - `irq` deasserts the cycle after the W1C clear of the last enabled flag.
- When undefined:
  - No `irq` port exists.
  - Offset 4 reads 0, and writes to it are ignored.

## Structure
- Shared package `io_pkg` holds:
  - The offset constants `IO_OFF_SW`, `IO_OFF_BTN`, `IO_OFF_PRESS`, `IO_OFF_LED`, `IO_OFF_MASK`.
  - The default `BASE_ADDR`.
  - The top-level decode helper used for the RAM/IO read mux.
- One sub-module, `io_debounce`, with parameter `DEBOUNCE_CYCLES` and ports `clock`, `reset`, `in`, `stable`. The top level instantiates it `N_SW + N_BTN` times via generate.

## Test plan
All scenarios use `DEBOUNCE_CYCLES` = 4, `BASE_ADDR` = 12'hF00, 5 buttons, 16 switches and LEDs.
- Reset sequence: hold `reset` = 0 with `SW` = 16'hFFFF, then release; read 0xF00 immediately → 0. After 6 cycles, read 0xF00 → 32'h0000FFFF.
- Glitch rejection: pulse `BTN[0]` high for 3 cycles → BTN and PRESS stay 0. Hold it high for 6 cycles → BTN reads 1 and PRESS reads 1.
- W1C and release: PRESS = 5'b00001. Write 1 to 0xF02 → reads 0; release the button → PRESS stays 0. Press `BTN[3]` → PRESS reads 5'b01000.
- Same-cycle conflict: W1C write of bit 2 on the exact cycle `BTN[2]` is accepted as pressed → PRESS[2] reads 1.
- LED and window: write 32'hDEADBEEF to 0xF03 → `LED` = 16'hBEEF the next cycle and a read returns 32'h0000BEEF. Write to 0xEFF → `sel` = 0, `LED` is unchanged and a read returns 0.
- `IO_IRQ_EN`: MASK = 5'b00010, then press `BTN[0]` → `irq` stays 0. Press `BTN[1]` → `irq` rises 1 cycle after the PRESS set. W1C bit 1 → `irq` falls next cycle.
